image_scan_ctrl: RTL and testbench

- Frame-scan controller that sequences the RGB pixel-pair read datapath: start-up (VSYNC) delay, per-line HSYNC blanking, then raster scan of row/col at 2 pixels per beat.
- Produces the read address and 3x3-window edge flags for the filter datapath.
- Adds a valid/ready handshake so the downstream image writer can stall the scan.
- Sits between the top-level start logic and the pixel memory/filter stage.

---
 rtl/image_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_image_scan_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/image_scan_ctrl.sv
// Frame-scan sequencer for the RGB pixel-pair read path: VSYNC start-up delay,
// per-line HSYNC blanking, then a stallable raster scan at two pixels per beat.
module image_scan_ctrl #(
  parameter int WIDTH          = 768,
  parameter int HEIGHT         = 512,
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic        out_ready,
  output logic        busy,
  output logic        VSYNC,
  output logic        HSYNC,
  output logic        out_valid,
  output logic [9:0]  row,
  output logic [10:0] col,
  output logic [18:0] rd_addr,
  output logic        edge_top,
  output logic        edge_bottom,
  output logic        edge_left,
  output logic        edge_right,
  output logic        line_done,
  output logic        frame_done
);

  // state | meaning: IDLE wait start, VSYNC start-up hold, HSYNC line blanking,
  // DATA pixel-pair beats, DONE one-cycle frame end
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_VSYNC = 3'd1;
  localparam logic [2:0] S_HSYNC = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [15:0] VS_LAST  = 16'(START_UP_DELAY - 1);
  localparam logic [15:0] HS_LAST  = 16'(HSYNC_DELAY - 1);
  localparam logic [10:0] COL_LAST = 11'(WIDTH - 2);
  localparam logic [9:0]  ROW_LAST = 10'(HEIGHT - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [9:0]  row_q, row_d;
  logic [10:0] col_q, col_d;
  logic [18:0] addr_q, addr_d;
  logic        line_done_q, line_done_d;
  logic        accept;

  assign accept = (state_q == S_DATA) && out_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    row_d       = row_q;
    col_d       = col_q;
    addr_d      = addr_q;
    line_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_VSYNC;
          row_d   = '0;
          col_d   = '0;
          addr_d  = '0;
        end
      end
      S_VSYNC: begin
        if (cnt_q == VS_LAST) begin
          state_d = S_HSYNC;
          cnt_d   = '0;
        end
      end
      S_HSYNC: begin
        if (cnt_q == HS_LAST) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        cnt_d = '0;
        if (accept) begin
          if (col_q != COL_LAST) begin
            col_d  = col_q + 11'd2;
            addr_d = addr_q + 19'd2;
          end else begin
            line_done_d = 1'b1;
            // the last pair of the frame keeps its address until DONE clears it
            if (row_q != ROW_LAST) begin
              row_d   = row_q + 10'd1;
              col_d   = '0;
              addr_d  = addr_q + 19'd2;
              state_d = S_HSYNC;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
        row_d   = '0;
        col_d   = '0;
        addr_d  = '0;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      addr_q      <= '0;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      addr_q      <= addr_d;
      line_done_q <= line_done_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign VSYNC       = (state_q == S_VSYNC);
  assign out_valid   = (state_q == S_DATA);
  assign HSYNC       = out_valid;
  assign row         = row_q;
  assign col         = col_q;
  assign rd_addr     = addr_q;
  assign edge_top    = out_valid && (row_q == '0);
  assign edge_bottom = out_valid && (row_q == ROW_LAST);
  assign edge_left   = out_valid && (col_q == '0);
  assign edge_right  = out_valid && (col_q == COL_LAST);
  assign line_done   = line_done_q;
  assign frame_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_image_scan_ctrl.sv
// Bench for image_scan_ctrl: a queue of expected beats built from raster order
// is consumed as beats are accepted, under fixed, stalled and random out_ready.
module tb_image_scan_ctrl;
  localparam int W   = 8;
  localparam int H   = 4;
  localparam int SUD = 3;
  localparam int HD  = 2;
  localparam int FRAME_LEN = SUD + H * (HD + W / 2) + 1;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic        busy, VSYNC, HSYNC, out_valid;
  logic [9:0]  row;
  logic [10:0] col;
  logic [18:0] rd_addr;
  logic        edge_top, edge_bottom, edge_left, edge_right;
  logic        line_done, frame_done;

  image_scan_ctrl #(.WIDTH(W), .HEIGHT(H), .START_UP_DELAY(SUD), .HSYNC_DELAY(HD)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .out_ready(out_ready),
    .busy(busy), .VSYNC(VSYNC), .HSYNC(HSYNC), .out_valid(out_valid),
    .row(row), .col(col), .rd_addr(rd_addr),
    .edge_top(edge_top), .edge_bottom(edge_bottom), .edge_left(edge_left),
    .edge_right(edge_right), .line_done(line_done), .frame_done(frame_done)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {int r; int c; int a;} beat_t;
  beat_t expq[$];
  int n_vec = 0;
  int n_err = 0;
  int beats, lines, frames, vs_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {busy, VSYNC, HSYNC, out_valid, row, col, rd_addr,
            edge_top, edge_bottom, edge_left, edge_right, line_done, frame_done};
  endfunction

  task automatic load_frame();
    expq.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c += 2)
        expq.push_back('{r, c, r * W + c});
    beats = 0; lines = 0; frames = 0; vs_cyc = 0;
  endtask

  // called at a falling edge once this cycle's inputs are set
  task automatic cycle_check();
    beat_t b;
    check("hsync_eq_valid", HSYNC, out_valid);
    if (out_valid) begin
      check("beat_pending", expq.size() > 0, 1);
      if (expq.size() > 0) begin
        b = expq[0];
        check("row", row, b.r);
        check("col", col, b.c);
        check("rd_addr", rd_addr, b.a);
        check("edges", {edge_top, edge_bottom, edge_left, edge_right},
              {b.r == 0, b.r == H - 1, b.c == 0, b.c == W - 2});
        if (out_ready) begin
          void'(expq.pop_front());
          beats++;
        end
      end
    end else begin
      check("edges_blank", {edge_top, edge_bottom, edge_left, edge_right}, 0);
    end
    if (line_done) lines++;
    if (frame_done) frames++;
    if (VSYNC) vs_cyc++;
  endtask

  // mode 0: ready=1, 1: random ready, 2: 5-cycle stall at (1,4), 3: ready=1 plus stray starts
  task automatic run_frame(input int mode);
    int k_fd, bp;
    bit sv, sd;
    load_frame();
    k_fd = -1; bp = 0; sv = 0; sd = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge HCLK);
      if (k == 0) check("idle_before_start", busy, 0);
      start = (k == 0);
      case (mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          out_ready = 1'b1;
          if (out_valid && row == 10'd1 && col == 11'd4 && bp < 5) begin
            out_ready = 1'b0;
            bp++;
            check("bp_addr", rd_addr, 12);
          end
        end
        default: out_ready = 1'b1;
      endcase
      if (mode == 3) begin
        if (VSYNC && !sv) begin start = 1'b1; sv = 1'b1; end
        if (out_valid && row == 10'd1 && !sd) begin start = 1'b1; sd = 1'b1; end
        if (frame_done) start = 1'b1;
      end
      cycle_check();
      if (frame_done) begin
        k_fd = k;
        break;
      end
    end
    check("frame_done_seen", k_fd >= 0, 1);
    if (mode == 0 || mode == 3) check("frame_len", k_fd, FRAME_LEN);
    check("beat_count", beats, W * H / 2);
    check("beats_left", expq.size(), 0);
    check("line_done_count", lines, H);
    check("frame_done_count", frames, 1);
    check("vsync_cycles", vs_cyc, SUD);
    if (mode == 2) check("bp_cycles", bp, 5);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge HCLK);
      start = 1'b0;
      out_ready = 1'b1;
      check("idle_busy", busy, 0);
      check("idle_regs", {row, col, rd_addr}, 0);
    end
  endtask

  initial begin
    bit found;
    #1;
    check("reset_outputs", all_outs(), 0);
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;

    run_frame(0);
    run_frame(3);
    idle_cycles(2);
    run_frame(2);
    repeat (4) run_frame(1);

    load_frame();
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge HCLK);
      start = (k == 0);
      out_ready = 1'b1;
      cycle_check();
      if (out_valid && row == 10'd2 && col == 11'd2) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_row2_col2", found, 1);
    #2 HRESET = 1'b1;
    #1 check("async_reset_outputs", all_outs(), 0);
    @(negedge HCLK);
    HRESET = 1'b0;
    out_ready = 1'b0;
    @(negedge HCLK);
    check("idle_after_reset", all_outs(), 0);
    run_frame(0);
    idle_cycles(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
